// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a fixed-latency ready/stall handshake.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses via err and suppress their stores.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int unsigned IdxW        = $clog2(DEPTH_WORDS);
    localparam bit          SingleCycle = (LATENCY == 1);
    localparam logic [3:0]  CntInit     = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_write_q, req_write_d;
    logic [IdxW-1:0]   req_idx_q, req_idx_d;
    logic [31:0]       req_wd_q, req_wd_d;
    logic              req_mis_q, req_mis_d;
    logic              ready_q, ready_d;
    logic [31:0]       rd_q, rd_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              req;
    logic [IdxW-1:0]   in_idx;
    logic              in_mis;
    logic              cur_write;
    logic [IdxW-1:0]   cur_idx;
    logic [31:0]       cur_wd;
    logic              cur_mis;
    logic              commit;
    logic              mem_we;
    logic              unused_addr;

    assign req    = MemRead | MemWrite;
    assign in_idx = addr[IdxW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = (addr[1:0] != 2'b00);
`else
    assign in_mis = 1'b0;
`endif

    // Bits above the word index are ignored, so addresses wrap modulo the array size.
    assign unused_addr = ^{addr[31:IdxW+2], addr[1:0]};

    // With single-cycle latency the commit edge is also the accept edge, so the
    // commit path must see the live inputs rather than the latched copy.
    always_comb begin
        cur_write = req_write_q;
        cur_idx   = req_idx_q;
        cur_wd    = req_wd_q;
        cur_mis   = req_mis_q;
        if (state_q == StIdle) begin
            cur_write = MemWrite;
            cur_idx   = in_idx;
            cur_wd    = wd;
            cur_mis   = in_mis;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_write_d = req_write_q;
        req_idx_d   = req_idx_q;
        req_wd_d    = req_wd_q;
        req_mis_d   = req_mis_q;
        commit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    req_write_d = MemWrite;
                    req_idx_d   = in_idx;
                    req_wd_d    = wd;
                    req_mis_d   = in_mis;
                    if (SingleCycle) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response flops are loaded only on the commit edge, so they pulse for the RESP cycle.
    always_comb begin
        ready_d = commit;
        err_d   = commit & cur_mis;
        rd_d    = 32'd0;
        if (commit && !cur_mis) begin
            rd_d = mem_q[cur_idx];
        end
    end

    // Reset aborts an in-flight store even when it lands on the commit edge.
    assign mem_we = commit & cur_write & ~cur_mis & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            req_write_q <= 1'b0;
            req_idx_q   <= '0;
            req_wd_q    <= 32'd0;
            req_mis_q   <= 1'b0;
            ready_q     <= 1'b0;
            rd_q        <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_write_q <= req_write_d;
            req_idx_q   <= req_idx_d;
            req_wd_q    <= req_wd_d;
            req_mis_q   <= req_mis_d;
            ready_q     <= ready_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
        end
    end

    // Storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cur_idx] <= cur_wd;
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = req & ~ready_q;

endmodule
